// File: rtl/mux2_arb_pkg.sv
// Shared types and select encodings for the two-requester round-robin mux arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2to1.sv
// Plain 2:1 multiplexer; select encoding follows SEL_A / SEL_B.
module mux2to1
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = (sel == SEL_B) ? d1 : d0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 datapath mux between two valid/ready streams.
// Grants last for a whole packet or MAX_BURST beats, whichever ends first.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    input  logic             y_ready,
    output logic             S,
    output logic             busy
);

    localparam int               CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) + 1 : 1;
    localparam bit               BURST_CAP = (MAX_BURST > 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = BURST_CAP ? CNT_W'(MAX_BURST - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             rr;
    logic             rr_nxt;
    logic             sel_nxt;
    logic             fire;
    logic             beat_last;
    logic             grant_done;

    // Handshake of the current owner and whether it ends the grant
    always_comb begin
        fire      = 1'b0;
        beat_last = 1'b0;
        case (state)
            GNT_A: begin
                fire      = a_valid & y_ready;
                beat_last = a_last;
            end
            GNT_B: begin
                fire      = b_valid & y_ready;
                beat_last = b_last;
            end
            default: begin
                fire      = 1'b0;
                beat_last = 1'b0;
            end
        endcase
        grant_done = fire & (beat_last | (BURST_CAP & (count == CNT_LAST)));
    end

    // Next state, burst count and round-robin pointer; release hands over with no bubble
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        rr_nxt    = rr;
        case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    state_nxt = (rr == SEL_B) ? GNT_B : GNT_A;
                end else if (a_valid) begin
                    state_nxt = GNT_A;
                end else if (b_valid) begin
                    state_nxt = GNT_B;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GNT_A: begin
                if (grant_done) begin
                    rr_nxt    = SEL_B;
                    count_nxt = '0;
                    if (b_valid) begin
                        state_nxt = GNT_B;
                    end else if (a_valid) begin
                        state_nxt = GNT_A;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (fire) begin
                    count_nxt = count + CNT_ONE;
                end else begin
                    count_nxt = count;
                end
            end
            GNT_B: begin
                if (grant_done) begin
                    rr_nxt    = SEL_A;
                    count_nxt = '0;
                    if (a_valid) begin
                        state_nxt = GNT_A;
                    end else if (b_valid) begin
                        state_nxt = GNT_B;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (fire) begin
                    count_nxt = count + CNT_ONE;
                end else begin
                    count_nxt = count;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
                rr_nxt    = SEL_A;
            end
        endcase

        // Select only moves on entry to a grant and holds through IDLE
        case (state_nxt)
            GNT_A:   sel_nxt = SEL_A;
            GNT_B:   sel_nxt = SEL_B;
            default: sel_nxt = S;
        endcase
    end

    // State, select, burst count and round-robin pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            S     <= SEL_A;
            count <= '0;
            rr    <= SEL_A;
        end else begin
            state <= state_nxt;
            S     <= sel_nxt;
            count <= count_nxt;
            rr    <= rr_nxt;
        end
    end

    // Handshake outputs decoded from the current grant
    always_comb begin
        y_valid = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state)
            GNT_A: begin
                y_valid = a_valid;
                a_ready = y_ready;
            end
            GNT_B: begin
                y_valid = b_valid;
                b_ready = y_ready;
            end
            default: begin
                y_valid = 1'b0;
                a_ready = 1'b0;
                b_ready = 1'b0;
            end
        endcase
        busy = (state != IDLE);
    end

    mux2to1 #(.WIDTH(WIDTH)) u_data_mux (
        .d0  (a_data),
        .d1  (b_data),
        .sel (S),
        .y   (y_data)
    );

    mux2to1 #(.WIDTH(1)) u_last_mux (
        .d0  (a_last),
        .d1  (b_last),
        .sel (S),
        .y   (y_last)
    );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed vector table, corner sequences
// and randomized traffic against a packet-level reference model.
`timescale 1ns/1ps
module tb_mux2_rr_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_valid = 1'b0, a_last = 1'b0, a_ready;
    logic [WIDTH-1:0] a_data = 8'h00;
    logic             b_valid = 1'b0, b_last = 1'b0, b_ready;
    logic [WIDTH-1:0] b_data = 8'h00;
    logic             y_valid, y_last, S, busy;
    logic             y_ready = 1'b0;
    logic [WIDTH-1:0] y_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready),
        .S(S), .busy(busy)
    );

    // Observed outputs packed as {y_valid, y_data, y_last, a_ready, b_ready, S, busy}
    typedef struct {
        string       name;
        logic        r, av, al, bv, bl, yr;
        logic [7:0]  ad, bd;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [13:0] pk(input logic yv, input logic [7:0] yd, input logic yl,
                                       input logic ar, input logic br, input logic s, input logic bz);
        return {yv, yd, yl, ar, br, s, bz};
    endfunction

    function automatic vec_t mk(input string nm, input logic r, input logic av, input logic [7:0] ad,
                                input logic al, input logic bv, input logic [7:0] bd, input logic bl,
                                input logic yr, input logic [13:0] e);
        vec_t v;
        v.name = nm; v.r = r; v.av = av; v.ad = ad; v.al = al;
        v.bv = bv; v.bd = bd; v.bl = bl; v.yr = yr; v.exp = e;
        return v;
    endfunction

    function automatic logic [13:0] observed();
        return {y_valid, y_data, y_last, a_ready, b_ready, S, busy};
    endfunction

    task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {yv,yd,yl,ar,br,S,busy}=%h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.r; a_valid = v.av; a_data = v.ad; a_last = v.al;
        b_valid = v.bv; b_data = v.bd; b_last = v.bl; y_ready = v.yr;
        #1;
        check(v.name, observed(), v.exp);
    endtask

    // Reference model: who owns the mux, beats taken in this grant, who is preferred next
    int   m_owner;  // 0 none, 1 A, 2 B
    int   m_beats;
    int   m_pref;   // 1 A, 2 B
    logic m_sel;

    task automatic model_reset();
        m_owner = 0; m_beats = 0; m_pref = 1; m_sel = 1'b0;
    endtask

    function automatic logic [13:0] model_out();
        logic yv;
        yv = (m_owner == 1) ? a_valid : ((m_owner == 2) ? b_valid : 1'b0);
        return pk(yv, m_sel ? b_data : a_data, m_sel ? b_last : a_last,
                  (m_owner == 1) && y_ready, (m_owner == 2) && y_ready, m_sel, m_owner != 0);
    endfunction

    task automatic model_clock();
        logic mv, ml, ov;
        int   other;
        if (m_owner == 0) begin
            if (a_valid && b_valid) m_owner = m_pref;
            else if (a_valid)       m_owner = 1;
            else if (b_valid)       m_owner = 2;
        end else begin
            other = 3 - m_owner;
            mv = (m_owner == 1) ? a_valid : b_valid;
            ml = (m_owner == 1) ? a_last  : b_last;
            ov = (m_owner == 1) ? b_valid : a_valid;
            if (mv && y_ready) begin
                m_beats++;
                if (ml || (MAX_BURST > 0 && m_beats == MAX_BURST)) begin
                    m_beats = 0;
                    m_pref  = other;
                    m_owner = ov ? other : m_owner;
                end
            end
        end
        if (m_owner != 0) m_sel = (m_owner == 2);
    endtask

    initial begin
        // Both requesters with 2-beat packets: grants alternate A,A,B,B,A,A with no gap
        vecs.push_back(mk("t1_rst", 1, 1, 8'hA1, 0, 1, 8'hB1, 0, 1, pk(0, 8'hA1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("t1_c0",  0, 1, 8'hA1, 0, 1, 8'hB1, 0, 1, pk(0, 8'hA1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("t1_c1",  0, 1, 8'hA1, 0, 1, 8'hB1, 0, 1, pk(1, 8'hA1, 0, 1, 0, 0, 1)));
        vecs.push_back(mk("t1_c2",  0, 1, 8'hA2, 1, 1, 8'hB1, 0, 1, pk(1, 8'hA2, 1, 1, 0, 0, 1)));
        vecs.push_back(mk("t1_c3",  0, 1, 8'hA3, 0, 1, 8'hB1, 0, 1, pk(1, 8'hB1, 0, 0, 1, 1, 1)));
        vecs.push_back(mk("t1_c4",  0, 1, 8'hA3, 0, 1, 8'hB2, 1, 1, pk(1, 8'hB2, 1, 0, 1, 1, 1)));
        vecs.push_back(mk("t1_c5",  0, 1, 8'hA3, 0, 1, 8'hB3, 0, 1, pk(1, 8'hA3, 0, 1, 0, 0, 1)));
        vecs.push_back(mk("t1_c6",  0, 1, 8'hA4, 1, 1, 8'hB3, 0, 1, pk(1, 8'hA4, 1, 1, 0, 0, 1)));
        vecs.push_back(mk("t1_c7",  0, 1, 8'hA5, 0, 1, 8'hB3, 0, 1, pk(1, 8'hB3, 0, 0, 1, 1, 1)));
        // A alone, one 3-beat packet
        vecs.push_back(mk("t2_rst", 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, pk(0, 8'h00, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("t2_c0",  0, 1, 8'h11, 0, 0, 8'h00, 0, 1, pk(0, 8'h11, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("t2_c1",  0, 1, 8'h11, 0, 0, 8'h00, 0, 1, pk(1, 8'h11, 0, 1, 0, 0, 1)));
        vecs.push_back(mk("t2_c2",  0, 1, 8'h22, 0, 0, 8'h00, 0, 1, pk(1, 8'h22, 0, 1, 0, 0, 1)));
        vecs.push_back(mk("t2_c3",  0, 1, 8'h33, 1, 0, 8'h00, 0, 1, pk(1, 8'h33, 1, 1, 0, 0, 1)));
        vecs.push_back(mk("t2_c4",  0, 0, 8'h00, 0, 0, 8'h00, 0, 1, pk(0, 8'h00, 0, 1, 0, 0, 1)));
        // A 6-beat packet cut after MAX_BURST beats, B served, then A's tail
        vecs.push_back(mk("t3_rst", 1, 1, 8'h01, 0, 1, 8'hB1, 0, 1, pk(0, 8'h01, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("t3_c0",  0, 1, 8'h01, 0, 1, 8'hB1, 0, 1, pk(0, 8'h01, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("t3_c1",  0, 1, 8'h01, 0, 1, 8'hB1, 0, 1, pk(1, 8'h01, 0, 1, 0, 0, 1)));
        vecs.push_back(mk("t3_c2",  0, 1, 8'h02, 0, 1, 8'hB1, 0, 1, pk(1, 8'h02, 0, 1, 0, 0, 1)));
        vecs.push_back(mk("t3_c3",  0, 1, 8'h03, 0, 1, 8'hB1, 0, 1, pk(1, 8'h03, 0, 1, 0, 0, 1)));
        vecs.push_back(mk("t3_c4",  0, 1, 8'h04, 0, 1, 8'hB1, 0, 1, pk(1, 8'h04, 0, 1, 0, 0, 1)));
        vecs.push_back(mk("t3_c5",  0, 1, 8'h05, 0, 1, 8'hB1, 0, 1, pk(1, 8'hB1, 0, 0, 1, 1, 1)));
        vecs.push_back(mk("t3_c6",  0, 1, 8'h05, 0, 1, 8'hB2, 1, 1, pk(1, 8'hB2, 1, 0, 1, 1, 1)));
        vecs.push_back(mk("t3_c7",  0, 1, 8'h05, 0, 0, 8'h00, 0, 1, pk(1, 8'h05, 0, 1, 0, 0, 1)));
        vecs.push_back(mk("t3_c8",  0, 1, 8'h06, 1, 0, 8'h00, 0, 1, pk(1, 8'h06, 1, 1, 0, 0, 1)));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // y_ready stalls 5 cycles; the held count still releases after exactly 4 fired beats
        apply(mk("t4_rst", 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, pk(0, 8'h00, 0, 0, 0, 0, 0)));
        apply(mk("t4_c0",  0, 1, 8'hC1, 0, 0, 8'h00, 0, 1, pk(0, 8'hC1, 0, 0, 0, 0, 0)));
        apply(mk("t4_c1",  0, 1, 8'hC1, 0, 0, 8'h00, 0, 1, pk(1, 8'hC1, 0, 1, 0, 0, 1)));
        for (int i = 0; i < 5; i++)
            apply(mk("t4_stall", 0, 1, 8'hC2, 0, 0, 8'h00, 0, 0, pk(1, 8'hC2, 0, 0, 0, 0, 1)));
        apply(mk("t4_resume", 0, 1, 8'hC2, 0, 0, 8'h00, 0, 1, pk(1, 8'hC2, 0, 1, 0, 0, 1)));
        apply(mk("t4_c3",  0, 1, 8'hC3, 0, 1, 8'hD1, 0, 1, pk(1, 8'hC3, 0, 1, 0, 0, 1)));
        apply(mk("t4_c4",  0, 1, 8'hC4, 0, 1, 8'hD1, 0, 1, pk(1, 8'hC4, 0, 1, 0, 0, 1)));
        apply(mk("t4_swap", 0, 1, 8'hC5, 0, 1, 8'hD1, 0, 1, pk(1, 8'hD1, 0, 0, 1, 1, 1)));

        // Asynchronous reset while B holds the grant, then A preferred
        apply(mk("t5_rst", 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, pk(0, 8'h00, 0, 0, 0, 0, 0)));
        apply(mk("t5_c0",  0, 0, 8'h00, 0, 1, 8'hE1, 0, 1, pk(0, 8'h00, 0, 0, 0, 0, 0)));
        apply(mk("t5_c1",  0, 0, 8'h00, 0, 1, 8'hE1, 0, 1, pk(1, 8'hE1, 0, 0, 1, 1, 1)));
        apply(mk("t5_pre", 0, 1, 8'hF1, 0, 1, 8'hE2, 0, 1, pk(1, 8'hE2, 0, 0, 1, 1, 1)));
        #1 rst = 1'b1;
        #1 check("t5_async", observed(), pk(0, 8'hF1, 0, 0, 0, 0, 0));
        apply(mk("t5_idle", 0, 1, 8'hF1, 0, 1, 8'hE2, 0, 1, pk(0, 8'hF1, 0, 0, 0, 0, 0)));
        apply(mk("t5_afirst", 0, 1, 8'hF1, 0, 1, 8'hE2, 0, 1, pk(1, 8'hF1, 0, 1, 0, 0, 1)));

        // a_valid gap mid-packet with B waiting: grant stays with A until its last beat
        apply(mk("t6_rst", 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, pk(0, 8'h00, 0, 0, 0, 0, 0)));
        apply(mk("t6_c0",  0, 1, 8'h61, 0, 0, 8'h00, 0, 1, pk(0, 8'h61, 0, 0, 0, 0, 0)));
        apply(mk("t6_c1",  0, 1, 8'h61, 0, 0, 8'h00, 0, 1, pk(1, 8'h61, 0, 1, 0, 0, 1)));
        for (int i = 0; i < 3; i++)
            apply(mk("t6_gap", 0, 0, 8'h00, 0, 1, 8'h71, 0, 1, pk(0, 8'h00, 0, 1, 0, 0, 1)));
        apply(mk("t6_last", 0, 1, 8'h62, 1, 1, 8'h71, 0, 1, pk(1, 8'h62, 1, 1, 0, 0, 1)));
        apply(mk("t6_b",    0, 0, 8'h00, 0, 1, 8'h71, 0, 1, pk(1, 8'h71, 0, 0, 1, 1, 1)));

        // Randomized traffic against the reference model, occasional resets included
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst     = (i == 0) ? 1'b1 : ($urandom_range(0, 99) == 0);
            a_valid = ($urandom_range(0, 3) != 0);
            a_data  = 8'($urandom);
            a_last  = ($urandom_range(0, 2) == 0);
            b_valid = ($urandom_range(0, 3) != 0);
            b_data  = 8'($urandom);
            b_last  = ($urandom_range(0, 2) == 0);
            y_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (rst) model_reset();
            check("random", observed(), model_out());
            if (!rst) model_clock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
